// File: rtl/shift_sched_pkg.sv
// Shared constants, types and helper functions for the shift scheduler.
//
// Contents:
//   W, SW   - datapath width (48) and shift-amount width (6)
//   IDW     - default response tag width for the default NREQ=2 build
//   id_t    - default response tag type
//   clog2   - ceiling log2, used to size the tag from NREQ
//   lzc     - leading-zero count of a W-bit word (used when
//             SHIFT_SCHED_LZC_EN is defined); an all-zero word returns W
package shift_sched_pkg;

  localparam int W   = 48;
  localparam int SW  = 6;
  localparam int IDW = 1;

  typedef logic [IDW-1:0] id_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Later (higher) set bits overwrite earlier ones, so the result is set
  // by the most significant one.
  function automatic logic [SW-1:0] lzc(input logic [W-1:0] d);
    logic [SW-1:0] n;
    n = SW'(W);
    for (int i = 0; i < W; i++) begin
      if (d[i]) n = SW'(W - 1 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/barrel_shl48.sv
// 48-bit logarithmic left barrel shifter, zero fill.
//
// Six cascaded conditional stages shift by 1, 2, 4, 8, 16 and 32. Amounts
// 48..63 push every bit out of the word, giving zero with no extra logic.
//
// Ports:
//   din   [47:0] operand
//   shamt [5:0]  left-shift amount
//   dout  [47:0] din << shamt
module barrel_shl48 (
  input  logic [47:0] din,
  input  logic [5:0]  shamt,
  output logic [47:0] dout
);

  logic [47:0] v;

  // NOTE: combinational logic uses blocking '=' and assigns every variable
  // before any conditional update, so no latch can be inferred.
  always_comb begin
    v = din;
    for (int s = 0; s < 6; s++) begin
      if (shamt[s]) v = v << (1 << s);
    end
    dout = v;
  end

endmodule

// File: rtl/shift_sched_rr_arb.sv
// Combinational round-robin arbiter.
//
// The search starts at ptr, wraps modulo NREQ and picks the first asserted
// request. grant_idx is the winner whenever any request is present; grant
// (one-hot) is raised only when advance is high, so the caller can gate the
// handshake without losing the index.
//
// Ports:
//   req       [NREQ-1:0] request vector
//   ptr       [IDW-1:0]  highest-priority requester this cycle
//   advance              permission to issue a grant
//   grant     [NREQ-1:0] one-hot grant or zero
//   grant_idx [IDW-1:0]  index of the selected requester
module shift_sched_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic           found;
  logic [IDW-1:0] idx;
  int             sum;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    idx       = '0;
    sum       = 0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found && advance) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one 48-bit left barrel shifter between
// NREQ requesters. Two-stage pipeline, one shift per cycle.
//
// Stage 1 registers the granted operand; the shifter sits between stage 1
// and stage 2; stage 2 drives the tagged response port.
//
// Build option: define SHIFT_SCHED_LZC_EN to honour req_norm (shift by the
// operand's leading-zero count and report it on out_lzc). Without it
// req_norm is ignored and out_lzc is always 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready[NREQ] per-requester handshake (ready one-hot or 0)
//   req_data [NREQ*W]         operands, requester i at [i*W +: W]
//   req_shamt[NREQ*SW]        left-shift amounts, packed the same way
//   req_norm [NREQ]           normalise request (LZC build only)
//   out_valid/out_ready       response handshake
//   out_data [W]              shifted result
//   out_id   [IDW]            originating requester
//   out_lzc  [SW]             shift amount applied by normalisation
module shift_sched #(
  parameter int NREQ = 2,
  parameter int W    = shift_sched_pkg::W,
  parameter int SW   = shift_sched_pkg::SW,
  parameter int IDW  = (shift_sched_pkg::clog2(NREQ) < 1) ? 1 : shift_sched_pkg::clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*W-1:0]  req_data,
  input  logic [NREQ*SW-1:0] req_shamt,
  input  logic [NREQ-1:0]  req_norm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDW-1:0]   out_id,
  output logic [SW-1:0]    out_lzc
);

  import shift_sched_pkg::*;

  logic             s1_valid;
  logic [W-1:0]     s1_data;
  logic [SW-1:0]    s1_shamt;
  logic [IDW-1:0]   s1_id;
  logic [IDW-1:0]   rr_ptr;

  logic             s1_en, s2_en, xfer;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [W-1:0]     sel_data;
  logic [SW-1:0]    sel_shamt;
  logic [SW-1:0]    s1_amt;
  logic [W-1:0]     shifted;
  logic [SW-1:0]    lzc_applied;

  assign s2_en = !out_valid || out_ready;
  assign s1_en = !s1_valid || s2_en;

  shift_sched_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .advance   (s1_en && !rst),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    sel_data  = '0;
    sel_shamt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_data  = req_data[i*W +: W];
        sel_shamt = req_shamt[i*SW +: SW];
      end
    end
  end

`ifdef SHIFT_SCHED_LZC_EN
  logic s1_norm;
  logic sel_norm;

  always_comb begin
    sel_norm = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) sel_norm = req_norm[i];
    end
  end

  always_ff @(posedge clk) begin
    if (s1_en && xfer) s1_norm <= sel_norm;
  end

  // The LZC lives between the stage-1 register and the shifter, so it
  // shares the stage-1 to stage-2 timing path and adds no latency.
  assign s1_amt      = s1_norm ? lzc(s1_data) : s1_shamt;
  assign lzc_applied = s1_amt;
`else
  logic unused_norm;
  assign unused_norm = ^req_norm;
  assign s1_amt      = s1_shamt;
  assign lzc_applied = '0;
`endif

  barrel_shl48 u_shl (
    .din   (s1_data),
    .shamt (s1_amt),
    .dout  (shifted)
  );

  // Stage 1 and arbitration pointer.
  // NOTE: sequential state uses non-blocking '<=' only; the payload
  // registers carry no reset because s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      rr_ptr   <= '0;
    end else if (s1_en) begin
      s1_valid <= xfer;
      if (xfer) begin
        rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_en && xfer) begin
      s1_data  <= sel_data;
      s1_shamt <= sel_shamt;
      s1_id    <= grant_idx;
    end
  end

  // Stage 2: response register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_lzc   <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= shifted;
        out_id   <= s1_id;
        out_lzc  <= lzc_applied;
      end
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Scoreboard bench for shift_sched (NREQ=2). Per-requester stimulus queues
// hold directed vectors with hand-computed results; accepts push expected
// responses, and a monitor pops and compares on every output transfer.
// Also builds with SHIFT_SCHED_LZC_EN defined.
module tb_shift_sched;

  localparam int NREQ = 2;

  typedef struct {
    logic [47:0] data;
    logic [5:0]  shamt;
    logic        norm;
    logic [47:0] exp_data;
    logic [5:0]  exp_lzc;
  } stim_t;

  typedef struct {
    logic [47:0] data;
    logic        id;
    logic [5:0]  lzc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*48-1:0] req_data;
  logic [NREQ*6-1:0]  req_shamt;
  logic [NREQ-1:0]  req_norm;
  logic             out_valid;
  logic             out_ready;
  logic [47:0]      out_data;
  logic [0:0]       out_id;
  logic [5:0]       out_lzc;

  stim_t stim_q[NREQ][$];
  exp_t  exp_q[$];
  int    grant_log[$];
  bit    acc[NREQ];
  int    cyc = 0;
  int    last_acc_cyc = 0;
  int    last_out_cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  shift_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .req_norm  (req_norm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_lzc   (out_lzc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // exp_lzc_norm is the count expected when norm=1 in the LZC build.
  task automatic push_req(input int i, input logic [47:0] data, input logic [5:0] shamt,
                          input logic norm, input logic [47:0] exp_data,
                          input logic [5:0] exp_lzc_norm);
    stim_t s;
    s.data     = data;
    s.shamt    = shamt;
    s.norm     = norm;
    s.exp_data = exp_data;
`ifdef SHIFT_SCHED_LZC_EN
    s.exp_lzc  = norm ? exp_lzc_norm : shamt;
`else
    s.exp_lzc  = 6'd0;
`endif
    stim_q[i].push_back(s);
  endtask

  // Driver: after each edge retire accepted vectors and present the next.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        void'(stim_q[i].pop_front());
        acc[i] = 1'b0;
      end
      if (stim_q[i].size() > 0) begin
        req_valid[i]           = 1'b1;
        req_data[i*48 +: 48]   = stim_q[i][0].data;
        req_shamt[i*6 +: 6]    = stim_q[i][0].shamt;
        req_norm[i]            = stim_q[i][0].norm;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // Accept recorder and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i] && stim_q[i].size() > 0) begin
        e.data = stim_q[i][0].exp_data;
        e.id   = i[0];
        e.lzc  = stim_q[i][0].exp_lzc;
        exp_q.push_back(e);
        grant_log.push_back(i);
        acc[i] = 1'b1;
        last_acc_cyc = cyc;
      end
    end
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_data), 64'hdead);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_id",   64'(out_id),   64'(e.id));
        check("out_lzc",  64'(out_lzc),  64'(e.lzc));
        last_out_cyc = cyc;
      end
    end
  end

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk);
      #2;
      done = (stim_q[0].size() == 0) && (stim_q[1].size() == 0) &&
             (exp_q.size() == 0) && !out_valid;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic wait_taken(input int i, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk);
      #2;
      done = (stim_q[i].size() == 0);
    end
    check(name, 64'(done), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_shamt = '0;
    req_norm  = '0;

    // Single request, held through reset: 1 << 47.
    push_req(0, 48'h0000_0000_0001, 6'd47, 1'b0, 48'h8000_0000_0000, 6'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid_held", 64'(req_valid), 64'b01);
    check("rst_req_ready",      64'(req_ready), 64'd0);
    check("rst_out_valid",      64'(out_valid), 64'd0);
    check("rst_out_data",       64'(out_data),  64'd0);
    check("rst_out_id",         64'(out_id),    64'd0);
    check("rst_out_lzc",        64'(out_lzc),   64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drain("t1_drain");
    check("t1_latency", 64'(last_out_cyc - last_acc_cyc), 64'd2);

    // Boundary shift amounts on requester 1; leaves rr_ptr at 0.
    push_req(1, 48'hFFFF_FFFF_FFFF, 6'd48, 1'b0, 48'h0, 6'd0);
    push_req(1, 48'hFFFF_FFFF_FFFF, 6'd63, 1'b0, 48'h0, 6'd0);
    push_req(1, 48'hFFFF_FFFF_FFFF, 6'd0,  1'b0, 48'hFFFF_FFFF_FFFF, 6'd0);
    drain("bound_drain");

    // Both requesters valid: grants must alternate 0,1,0,1.
    grant_log.delete();
    push_req(0, 48'h1, 6'd1, 1'b0, 48'h2, 6'd0);
    push_req(0, 48'h1, 6'd1, 1'b0, 48'h2, 6'd0);
    push_req(1, 48'h1, 6'd2, 1'b0, 48'h4, 6'd0);
    push_req(1, 48'h1, 6'd2, 1'b0, 48'h4, 6'd0);
    drain("rr_drain");
    check("rr_grant_count", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4) begin
      check("rr_grant0", 64'(grant_log[0]), 64'd0);
      check("rr_grant1", 64'(grant_log[1]), 64'd1);
      check("rr_grant2", 64'(grant_log[2]), 64'd0);
      check("rr_grant3", 64'(grant_log[3]), 64'd1);
    end

    // Backpressure: fill both stages, stall 5 cycles, then release.
    out_ready = 1'b0;
    push_req(0, 48'h1, 6'd3, 1'b0, 48'h8,  6'd0);
    push_req(0, 48'h1, 6'd5, 1'b0, 48'h20, 6'd0);
    push_req(1, 48'h1, 6'd4, 1'b0, 48'h10, 6'd0);
    repeat (4) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data",  64'(out_data),  64'h8);
      check("bp_out_id",    64'(out_id),    64'd0);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("bp_drain");

    // Reset with two results in flight; last accept is req 0, so rr_ptr=1.
    out_ready = 1'b0;
    push_req(1, 48'h1, 6'd6, 1'b0, 48'h40, 6'd0);
    wait_taken(1, "rst_fill1");
    push_req(0, 48'h1, 6'd7, 1'b0, 48'h80, 6'd0);
    wait_taken(0, "rst_fill0");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data",  64'(out_data),  64'd0);
    exp_q.delete();
    grant_log.delete();
    out_ready = 1'b1;
    push_req(0, 48'h1, 6'd8, 1'b0, 48'h100, 6'd0);
    push_req(1, 48'h1, 6'd9, 1'b0, 48'h200, 6'd0);
    drain("midrst_drain");
    check("midrst_grant_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      check("midrst_first_grant", 64'(grant_log[0]), 64'd0);
    end

`ifdef SHIFT_SCHED_LZC_EN
    // Normalisation: shamt is ignored when norm=1.
    push_req(0, 48'h0000_0F00_0000, 6'd3, 1'b1, 48'hF000_0000_0000, 6'd20);
    push_req(1, 48'h0,              6'd5, 1'b1, 48'h0,              6'd48);
    drain("norm_drain");
`else
    // Without the LZC build req_norm has no effect.
    push_req(0, 48'h1, 6'd4, 1'b1, 48'h10, 6'd0);
    drain("norm_ignored_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
